// File: rtl/sw_input_debounce_if.sv
// Board-input bundle between the raw switch/key pins and the debounce block.
// The master side drives the raw inputs and the slave side drives the conditioned outputs.
interface sw_input_debounce_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] port_sw;
    logic             step_key_n;
    logic             repeat_en;
    logic [WIDTH-1:0] port_out;
    logic             port_changed;
    logic             step_pulse;
    logic             step_held;

    modport master (
        output port_sw, step_key_n, repeat_en,
        input  port_out, port_changed, step_pulse, step_held
    );

    modport slave (
        input  port_sw, step_key_n, repeat_en,
        output port_out, port_changed, step_pulse, step_held
    );
endinterface

// File: rtl/sw_input_debounce.sv
// Synchronises and debounces the port switches and the step key.
// Turns the debounced key into single-cycle step strobes, with optional auto-repeat.
module sw_input_debounce #(
    parameter int WIDTH         = 8,
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int CNT_WIDTH     = 25
) (
    input  logic                clk,
    input  logic                rst,
    sw_input_debounce_if.slave  bus
);

    // The port bits and the step key share one synchroniser/debounce datapath; the key is the top bit.
    localparam int NB  = WIDTH + 1;
    localparam int KEY = WIDTH;

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef enum logic { IDLE, HELD } step_state_t;

    localparam cnt_t DEB_LAST = cnt_t'(DEB_CYCLES - 1);
    localparam cnt_t REP_LAST = cnt_t'(REPEAT_CYCLES - 1);

    // The raw key is active-low, so its synchroniser resets to the released level.
    localparam logic [NB-1:0] SYNC_RST = {1'b1, {WIDTH{1'b0}}};

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1, sync2;
    logic [NB-1:0] s_vec;
    logic [NB-1:0] d, d_nxt;
    cnt_t          deb_cnt     [NB];
    cnt_t          deb_cnt_nxt [NB];
    logic          port_accept;
    logic          port_changed_q;

    logic          rep_sync1, rep_sync2;
    step_state_t   state, state_nxt;
    cnt_t          rep_cnt, rep_cnt_nxt;
    logic          pulse_nxt;
    logic          step_pulse_q;
    logic          kd_nxt;

    assign raw = {bus.step_key_n, bus.port_sw};

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours (essential in a shift chain).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= SYNC_RST;
            sync2     <= SYNC_RST;
            rep_sync1 <= 1'b0;
            rep_sync2 <= 1'b0;
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            rep_sync1 <= bus.repeat_en;
            rep_sync2 <= rep_sync1;
        end
    end

    // Key bit is inverted here so that 1 means "pressed" everywhere downstream.
    assign s_vec = {~sync2[KEY], sync2[WIDTH-1:0]};

    // NOTE: every variable written in this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        d_nxt = d;
        for (int i = 0; i < NB; i++) begin
            deb_cnt_nxt[i] = '0;
            if (s_vec[i] != d[i]) begin
                if (deb_cnt[i] == DEB_LAST) begin
                    d_nxt[i] = s_vec[i];
                end else begin
                    deb_cnt_nxt[i] = deb_cnt[i] + cnt_t'(1);
                end
            end
        end
    end

    // Several bits accepted on the same edge still produce a single change pulse.
    assign port_accept = (d_nxt[WIDTH-1:0] != d[WIDTH-1:0]);

    // NOTE: the per-bit counter array is only NB entries of flops, not a RAM, so it is
    // reset like any other register to discard partial debounce progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            d              <= '0;
            port_changed_q <= 1'b0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            d              <= d_nxt;
            port_changed_q <= port_accept;
            for (int i = 0; i < NB; i++) begin
                deb_cnt[i] <= deb_cnt_nxt[i];
            end
        end
    end

    // The FSM looks at the key value being accepted on this edge, so the press strobe
    // lines up with the debounced acceptance instead of trailing it by a cycle.
    assign kd_nxt = d_nxt[KEY];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rep_cnt      <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            rep_cnt      <= rep_cnt_nxt;
            step_pulse_q <= pulse_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = rep_cnt;
        pulse_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (kd_nxt) begin
                    state_nxt   = HELD;
                    pulse_nxt   = 1'b1;
                    rep_cnt_nxt = '0;
                end
            end
            HELD: begin
                if (!kd_nxt) begin
                    // Release wins over a repeat strobe falling due on the same edge.
                    state_nxt   = IDLE;
                    rep_cnt_nxt = '0;
                end else if (rep_sync2) begin
                    if (rep_cnt == REP_LAST) begin
                        pulse_nxt   = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + cnt_t'(1);
                    end
                end else begin
                    rep_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = IDLE;
                rep_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.port_out     = d[WIDTH-1:0];
    assign bus.port_changed = port_changed_q;
    assign bus.step_pulse   = step_pulse_q;
    assign bus.step_held    = (state == HELD);

endmodule

// File: tb/tb_sw_input_debounce.sv
// Bench for sw_input_debounce with short debounce/repeat intervals.
// Expected output events are queued when stimulus is driven and checked on the falling edge.
module tb_sw_input_debounce;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;
    localparam int REP   = 10;
    localparam int LAT   = DEB + 2;

    typedef enum { EV_PORT, EV_STEP, EV_HELD, EV_RST } ev_kind_t;

    typedef struct {
        int        due;
        ev_kind_t  kind;
        logic [7:0] val;
    } ev_t;

    typedef struct {
        logic [7:0] sw;
        int         hold;
        bit         chg;
        logic [7:0] port;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    ev_t        sb[$];
    logic [7:0] exp_port = '0;
    logic       exp_held = 1'b0;
    logic       mon_chg;
    logic       mon_pulse;
    vec_t       vecs [11];

    sw_input_debounce_if #(.WIDTH(WIDTH)) bus ();

    sw_input_debounce #(
        .WIDTH        (WIDTH),
        .DEB_CYCLES   (DEB),
        .REPEAT_CYCLES(REP),
        .CNT_WIDTH    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input ev_kind_t k, input int delay, input logic [7:0] v);
        ev_t e;
        e.due  = cyc + delay;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Falling-edge monitor: applies any events due this cycle, then compares every output.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon_chg   = 1'b0;
            mon_pulse = 1'b0;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    case (sb[i].kind)
                        EV_PORT: begin exp_port = sb[i].val; mon_chg = 1'b1; end
                        EV_STEP: mon_pulse = 1'b1;
                        EV_HELD: exp_held = sb[i].val[0];
                        EV_RST:  begin exp_port = '0; exp_held = 1'b0; end
                        default: ;
                    endcase
                    sb.delete(i);
                end else if (sb[i].due < cyc) begin
                    check("sb_overdue", sb[i].due, cyc);
                    sb.delete(i);
                end
            end
            check("port_out",     bus.port_out,     exp_port);
            check("port_changed", bus.port_changed, mon_chg);
            check("step_pulse",   bus.step_pulse,   mon_pulse);
            check("step_held",    bus.step_held,    exp_held);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Port stimulus: value, cycles held, whether a debounced change follows, resulting port_out.
        vecs[0]  = '{sw: 8'hA5, hold: 10, chg: 1'b1, port: 8'hA5};
        vecs[1]  = '{sw: 8'hA4, hold: 10, chg: 1'b1, port: 8'hA4};
        vecs[2]  = '{sw: 8'hA5, hold: 2,  chg: 1'b0, port: 8'hA4};
        vecs[3]  = '{sw: 8'hA4, hold: 2,  chg: 1'b0, port: 8'hA4};
        vecs[4]  = '{sw: 8'hA5, hold: 10, chg: 1'b1, port: 8'hA5};
        vecs[5]  = '{sw: 8'hA5, hold: 8,  chg: 1'b0, port: 8'hA5};
        vecs[6]  = '{sw: 8'h5A, hold: 10, chg: 1'b1, port: 8'h5A};
        vecs[7]  = '{sw: 8'hFF, hold: 3,  chg: 1'b0, port: 8'h5A};
        vecs[8]  = '{sw: 8'h5A, hold: 10, chg: 1'b0, port: 8'h5A};
        vecs[9]  = '{sw: 8'hFF, hold: 4,  chg: 1'b1, port: 8'hFF};
        vecs[10] = '{sw: 8'h5A, hold: 10, chg: 1'b1, port: 8'h5A};

        bus.port_sw    = 8'h00;
        bus.step_key_n = 1'b1;
        bus.repeat_en  = 1'b0;

        // Reset for three edges, then idle inputs must leave every output quiet.
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(8);

        // Table-driven port debounce, including glitches of DEB-1 and DEB cycles.
        for (int v = 0; v < 11; v++) begin
            bus.port_sw = vecs[v].sw;
            if (vecs[v].chg) expect_ev(EV_PORT, LAT, vecs[v].port);
            wait_cycles(vecs[v].hold);
        end
        wait_cycles(4);

        // Key held 30 cycles without repeat: one press strobe only.
        bus.step_key_n = 1'b0;
        expect_ev(EV_STEP, LAT, 8'h00);
        expect_ev(EV_HELD, LAT, 8'h01);
        wait_cycles(30);
        bus.step_key_n = 1'b1;
        expect_ev(EV_HELD, LAT, 8'h00);
        wait_cycles(12);

        // Key held 40 cycles with repeat: strobes every REP cycles, none once released.
        bus.repeat_en = 1'b1;
        wait_cycles(4);
        bus.step_key_n = 1'b0;
        for (int p = 0; p < 4; p++) expect_ev(EV_STEP, LAT + p * REP, 8'h00);
        expect_ev(EV_HELD, LAT, 8'h01);
        wait_cycles(40);
        bus.step_key_n = 1'b1;
        expect_ev(EV_HELD, LAT, 8'h00);
        wait_cycles(12);

        // Reset in the middle of an auto-repeat hold, with a fresh port value settled.
        bus.port_sw = 8'h3C;
        expect_ev(EV_PORT, LAT, 8'h3C);
        wait_cycles(10);
        bus.step_key_n = 1'b0;
        expect_ev(EV_STEP, LAT, 8'h00);
        expect_ev(EV_STEP, LAT + REP, 8'h00);
        expect_ev(EV_HELD, LAT, 8'h01);
        wait_cycles(20);
        rst = 1'b1;
        sb.delete();
        expect_ev(EV_RST, 1, 8'h00);
        wait_cycles(3);
        rst = 1'b0;
        expect_ev(EV_PORT, LAT, 8'h3C);
        expect_ev(EV_STEP, LAT, 8'h00);
        expect_ev(EV_HELD, LAT, 8'h01);
        expect_ev(EV_STEP, LAT + REP, 8'h00);
        wait_cycles(20);
        bus.step_key_n = 1'b1;
        expect_ev(EV_HELD, LAT, 8'h00);
        wait_cycles(12);

        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
